apb_bus_arbiter: RTL
====================

Name: apb_bus_arbiter

Overview:
- Shares the single APB master port between two requesters: requester 0 is the controller core, requester 1 is the loader/debug port.
- Arbitrates between them round-robin and sequences the APB SETUP/ACCESS phases.
- Decodes the one-hot slave select from the address, waits on PREADY, and returns read data and error per requester.
- Includes a PREADY timeout so a dead slave cannot hang the controller.

Parameters:
- DATA_WIDTH, 16, width of PWDATA/PRDATA and requester data.
- ADDR_WIDTH, 16, width of PADDR and requester addresses.
- SEL_WIDTH, 2, number of slaves; o_PSEL is one-hot of this width.
- TIMEOUT, 15, maximum ACCESS cycles waiting for PREADY before abort (1..255).

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req_valid  in  2  per-requester request; held until the matching o_req_ack
- i_req_write  in  2  1 = write, 0 = read
- i_req_addr  in  2*ADDR_WIDTH  requester r at bits [r*ADDR_WIDTH +: ADDR_WIDTH]
- i_req_wdata  in  2*DATA_WIDTH  packed as for addresses
- o_req_ack  out  2  one-cycle pulse: request captured
- o_req_done  out  2  one-cycle pulse: transfer finished
- o_req_rdata  out  DATA_WIDTH  read data, valid with o_req_done
- o_req_err  out  1  error flag, valid with o_req_done
- o_PADDR  out  ADDR_WIDTH  APB address
- o_PSEL  out  SEL_WIDTH  one-hot slave select
- o_PENABLE  out  1  APB enable
- o_PWRITE  out  1  APB direction
- o_PWDATA  out  DATA_WIDTH  APB write data
- i_PREADY  in  1  slave ready
- i_PRDATA  in  DATA_WIDTH  slave read data
- i_PSLVERR  in  1  slave error
- o_busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (i_rst high at an edge): state IDLE; every output 0; last_grant = 1, so requester 0 wins first; timeout counter 0. Any in-flight transfer is dropped silently: no done pulse, PSEL/PENABLE low on the next cycle.
- FSM states: IDLE, SETUP, ACCESS.
- Arbitration happens only at an edge where the state is IDLE, or in ACCESS with i_PREADY high or a timeout.
  - Only one valid: grant it.
  - Both valid: grant !last_grant.
  - last_grant is updated to the granted requester.
- Grant edge: capture addr, wdata and write into o_PADDR, o_PWDATA and o_PWRITE.
  - Set o_PSEL[addr[ADDR_WIDTH-1 -: $clog2(SEL_WIDTH)]].
  - Out-of-range index (non-power-of-2 SEL_WIDTH): no PSEL; the transfer completes as error on the next cycle.
  - o_PENABLE = 0, o_req_ack[g] = 1 for exactly this SETUP cycle, state becomes SETUP.
- SETUP -> ACCESS unconditionally next edge; o_PENABLE = 1; timeout counter cleared.
- ACCESS:
  - i_PREADY low: hold all APB outputs and increment the counter.
  - Counter reaching TIMEOUT: treated as completion with err = 1 and rdata = 0.
  - i_PREADY high: complete.
- Completion edge:
  - o_req_done[g] = 1 for one cycle.
  - o_req_rdata = i_PRDATA for reads, 0 for writes.
  - o_req_err = i_PSLVERR, or 1 on timeout.
  - o_PENABLE = 0.
  - If any i_req_valid is high at this edge: go directly to SETUP for the new grant; PSEL stays high if the same slave is selected. No idle cycle.
  - Otherwise: IDLE with PSEL = 0.
- Latency: a request valid at edge N (IDLE) gives ack in cycle N+1 (SETUP) and ACCESS in N+2. With zero-wait PREADY, done is in cycle N+3. Minimum 2 APB cycles per transfer, back-to-back.
- Requester contract: drop valid (or present the next request) in the cycle after ack. Arbitration never occurs in the SETUP cycle, so an acked request is never taken twice.
- o_req_rdata/o_req_err hold their last values between done pulses. o_req_done/o_req_ack are 0 except in their pulse cycles.
- All outputs are registered; no combinational path from i_PREADY or i_req_valid to any output.

Test Plan:
- Single write: req0 write, addr 0x0010, data 0xBEEF, PREADY tied 1.
  - Required: ack0 in cycle 1; PSEL = 01, PENABLE 0 in cycle 1 and 1 in cycle 2; done0 in cycle 3; err 0; o_busy low in cycle 4.
- Read with waits: req1 read, addr 0x8004, PREADY low 3 ACCESS cycles, PRDATA = 0x1234.
  - Required: PSEL = 10; ACCESS lasts 4 cycles; done1 with rdata 0x1234.
- Contention: both requesters valid continuously for 4 transfers.
  - Required: grant order 0, 1, 0, 1; each transfer starts SETUP on the cycle after the previous completion; no IDLE cycles.
- Timeout: slave never asserts PREADY.
  - Required: done after exactly TIMEOUT = 15 ACCESS cycles with err 1 and rdata 0; bus returns to IDLE.
- Slave error: PSLVERR = 1 with PREADY on a write.
  - Required: done with err 1; the following transfer reports err 0.
- Reset mid-ACCESS: i_rst high for 1 cycle during a wait state.
  - Required: next cycle all outputs 0, no done pulse; after release, req0 wins a simultaneous request.

Source files
------------

// File: rtl/apb_bus_arbiter.sv
// apb_bus_arbiter
//   Shares one APB master port between two requesters (0 = controller core,
//   1 = loader/debug port). Round-robin arbitration, SETUP/ACCESS sequencing,
//   one-hot slave select decoded from the top address bits, and a PREADY
//   timeout so a dead slave cannot hang the controller.
//
// Ports
//   i_clk, i_rst            clock (rising edge), synchronous active-high reset
//   i_req_valid/write       per-requester request and direction
//   i_req_addr/wdata        requester r packed at [r*W +: W]
//   o_req_ack               one-cycle pulse in the SETUP cycle of a grant
//   o_req_done              one-cycle pulse when the transfer finishes
//   o_req_rdata, o_req_err  result, valid with o_req_done, held otherwise
//   o_P*, i_P*              APB master signals
//   o_busy                  high whenever the FSM is not IDLE
module apb_bus_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [1:0]              i_req_valid,
  input  logic [1:0]              i_req_write,
  input  logic [2*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [2*DATA_WIDTH-1:0] i_req_wdata,
  output logic [1:0]              o_req_ack,
  output logic [1:0]              o_req_done,
  output logic [DATA_WIDTH-1:0]   o_req_rdata,
  output logic                    o_req_err,
  output logic [ADDR_WIDTH-1:0]   o_PADDR,
  output logic [SEL_WIDTH-1:0]    o_PSEL,
  output logic                    o_PENABLE,
  output logic                    o_PWRITE,
  output logic [DATA_WIDTH-1:0]   o_PWDATA,
  input  logic                    i_PREADY,
  input  logic [DATA_WIDTH-1:0]   i_PRDATA,
  input  logic                    i_PSLVERR,
  output logic                    o_busy
);

  localparam int IDX_W = (SEL_WIDTH > 1) ? $clog2(SEL_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t                state, state_nx;
  logic                  last_grant;  // requester granted most recently
  logic                  cur;         // requester owning the current transfer
  logic                  bad_sel;     // current transfer decoded to no slave
  logic [7:0]            cnt;         // ACCESS wait cycles seen so far
  logic                  any_valid, gnt, timeout, finish, arb, sel_ok;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [IDX_W-1:0]      idx;
  logic [SEL_WIDTH-1:0]  sel_oh;

  always_comb begin
    any_valid = |i_req_valid;
    // Both valid: alternate. One valid: that one.
    gnt       = (&i_req_valid) ? ~last_grant : i_req_valid[1];
    g_addr    = gnt ? i_req_addr[ADDR_WIDTH +: ADDR_WIDTH] : i_req_addr[0 +: ADDR_WIDTH];
    idx       = (SEL_WIDTH > 1) ? g_addr[ADDR_WIDTH-1 -: IDX_W] : '0;
    // Only reachable as false when SEL_WIDTH is not a power of two.
    sel_ok    = 32'(idx) < SEL_WIDTH;
    sel_oh    = sel_ok ? (SEL_WIDTH'(1) << idx) : '0;
    // Timeout fires on the TIMEOUT-th ACCESS edge without PREADY.
    timeout   = (state == ACCESS) && !i_PREADY && (cnt == 8'(TIMEOUT - 1));
    finish    = (state == ACCESS) && (i_PREADY || timeout);
    arb       = any_valid && ((state == IDLE) || finish);

    state_nx = state;
    case (state)
      IDLE:    if (any_valid) state_nx = SETUP;
      SETUP:   state_nx = bad_sel ? IDLE : ACCESS;
      ACCESS:  if (finish) state_nx = any_valid ? SETUP : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_req_ack   <= '0;
      o_req_done  <= '0;
      o_req_rdata <= '0;
      o_req_err   <= 1'b0;
      o_PADDR     <= '0;
      o_PSEL      <= '0;
      o_PENABLE   <= 1'b0;
      o_PWRITE    <= 1'b0;
      o_PWDATA    <= '0;
      o_busy      <= 1'b0;
      last_grant  <= 1'b1;
      cur         <= 1'b0;
      bad_sel     <= 1'b0;
      cnt         <= '0;
    end else begin
      o_req_ack  <= '0;
      o_req_done <= '0;
      o_busy     <= (state_nx != IDLE);

      case (state)
        SETUP: begin
          if (bad_sel) begin
            // No slave to talk to: report an error straight away.
            o_req_done[cur] <= 1'b1;
            o_req_rdata     <= '0;
            o_req_err       <= 1'b1;
            o_PSEL          <= '0;
          end else begin
            o_PENABLE <= 1'b1;
            cnt       <= '0;
          end
        end
        ACCESS: begin
          if (finish) begin
            o_req_done[cur] <= 1'b1;
            o_req_rdata     <= (timeout || o_PWRITE) ? '0 : i_PRDATA;
            o_req_err       <= timeout ? 1'b1 : i_PSLVERR;
            o_PENABLE       <= 1'b0;
            o_PSEL          <= '0;  // overridden below on a back-to-back grant
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase

      if (arb) begin
        cur            <= gnt;
        last_grant     <= gnt;
        o_req_ack[gnt] <= 1'b1;
        o_PADDR        <= g_addr;
        o_PWDATA       <= gnt ? i_req_wdata[DATA_WIDTH +: DATA_WIDTH] : i_req_wdata[0 +: DATA_WIDTH];
        o_PWRITE       <= i_req_write[gnt];
        o_PSEL         <= sel_oh;
        o_PENABLE      <= 1'b0;
        bad_sel        <= !sel_ok;
      end
    end
  end

endmodule
